// File: rtl/softshell_wb_initiator.sv
// Single-outstanding Wishbone classic initiator: command in IDLE, bus cycle in BUS, response held in RESP.
// Minimum latency is two cycles from acceptance to rsp_valid_o; the response holds until rsp_ready_i, and no command is accepted meanwhile.
module softshell_wb_initiator #(
  parameter int TIMEOUT = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_adr_i,
  input  logic [31:0] req_dat_i,
  input  logic [3:0]  req_sel_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_dat_o,
  output logic        rsp_err_o,
  output logic        rsp_timeout_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [15:0] wait_cnt;
  logic        accept;
  logic        timeout_hit;

  // Ready is gated by reset so nothing is offered while reset is held.
  assign req_ready_o = (state == IDLE) && !wb_rst_i;
  assign accept      = req_valid_i && req_ready_o;
  assign timeout_hit = (wait_cnt == WAIT_LAST);
  assign wbm_cyc_o   = (state == BUS);
  assign wbm_stb_o   = (state == BUS);
  assign rsp_valid_o = (state == RESP);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = BUS;
      BUS:  if (wbm_ack_i || wbm_err_i || timeout_hit) state_nxt = RESP;
      RESP: if (rsp_ready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      wbm_we_o      <= 1'b0;
      wbm_sel_o     <= '0;
      wbm_adr_o     <= '0;
      wbm_dat_o     <= '0;
      rsp_dat_o     <= '0;
      rsp_err_o     <= 1'b0;
      rsp_timeout_o <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        wbm_we_o  <= req_we_i;
        wbm_sel_o <= req_sel_i;
        wbm_adr_o <= req_adr_i;
        wbm_dat_o <= req_dat_i;
        wait_cnt  <= '0;
      end
      if (state == BUS) begin
        // ERR outranks ACK, and either outranks a timeout landing on the same edge.
        if (wbm_err_i) begin
          rsp_dat_o     <= wbm_dat_i;
          rsp_err_o     <= 1'b1;
          rsp_timeout_o <= 1'b0;
        end else if (wbm_ack_i) begin
          rsp_dat_o     <= wbm_dat_i;
          rsp_err_o     <= 1'b0;
          rsp_timeout_o <= 1'b0;
        end else if (timeout_hit) begin
          rsp_err_o     <= 1'b1;
          rsp_timeout_o <= 1'b1;
        end else begin
          wait_cnt <= wait_cnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_softshell_wb_initiator.sv
// Directed and randomized transactions against a transaction-level model of the initiator.
module tb_softshell_wb_initiator;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_adr, req_dat;
  logic [3:0]  req_sel;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_to;
  logic [31:0] rsp_dat;
  logic        wbm_cyc, wbm_stb, wbm_we;
  logic [3:0]  wbm_sel;
  logic [31:0] wbm_adr, wbm_dat_o, wbm_dat_i;
  logic        wbm_ack, wbm_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  softshell_wb_initiator #(.TIMEOUT(TO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_adr_i(req_adr), .req_dat_i(req_dat), .req_sel_i(req_sel),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat),
    .rsp_err_o(rsp_err), .rsp_timeout_o(rsp_to),
    .wbm_cyc_o(wbm_cyc), .wbm_stb_o(wbm_stb), .wbm_we_o(wbm_we),
    .wbm_sel_o(wbm_sel), .wbm_adr_o(wbm_adr), .wbm_dat_o(wbm_dat_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack), .wbm_err_i(wbm_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // kind: 0 ack, 1 err, 2 ack+err, 3 silent slave. waits = wait states before the reply.
  task automatic run_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input int waits, input int kind,
                         input logic [31:0] rdat, input int bp);
    int          stb_cnt;
    int          exp_stb;
    logic        exp_to, exp_err;
    logic [31:0] h_dat;
    logic        h_err, h_to;
    exp_to  = (kind == 3) || (waits + 1 > TO);
    exp_stb = exp_to ? TO : waits + 1;
    exp_err = exp_to || (kind != 0);

    req_valid = 1'b1; req_we = we; req_adr = adr; req_dat = dat; req_sel = sel;
    chk("ready_in_idle", 32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0; req_adr = $urandom; req_dat = $urandom; req_sel = 4'($urandom); req_we = ~we;

    stb_cnt = 0;
    while (wbm_stb && stb_cnt < 64) begin
      stb_cnt++;
      chk("cyc_with_stb", 32'(wbm_cyc), 32'd1);
      chk("bus_adr", wbm_adr, adr);
      chk("bus_dat", wbm_dat_o, dat);
      chk("bus_sel", 32'(wbm_sel), 32'(sel));
      chk("bus_we", 32'(wbm_we), 32'(we));
      chk("ready_in_bus", 32'(req_ready), 32'd0);
      if (kind != 3 && stb_cnt == waits + 1) begin
        wbm_ack = (kind == 0 || kind == 2);
        wbm_err = (kind == 1 || kind == 2);
        wbm_dat_i = rdat;
      end else begin
        wbm_dat_i = $urandom;
      end
      step();
      wbm_ack = 1'b0; wbm_err = 1'b0;
    end

    chk("stb_cycles", 32'(stb_cnt), 32'(exp_stb));
    chk("rsp_valid_after_bus", 32'(rsp_valid), 32'd1);
    chk("cyc_dropped", 32'(wbm_cyc), 32'd0);
    chk("rsp_err", 32'(rsp_err), 32'(exp_err));
    chk("rsp_timeout", 32'(rsp_to), 32'(exp_to));
    if (!we && !exp_err) chk("rsp_dat", rsp_dat, rdat);
    h_dat = rsp_dat; h_err = rsp_err; h_to = rsp_to;

    if (exp_to) begin
      wbm_ack = 1'b1; wbm_dat_i = ~h_dat;
      step();
      wbm_ack = 1'b0;
      chk("late_ack_valid", 32'(rsp_valid), 32'd1);
      chk("late_ack_dat", rsp_dat, h_dat);
      chk("late_ack_to", 32'(rsp_to), 32'd1);
    end

    for (int i = 0; i < bp; i++) begin
      req_valid = 1'b1;
      step();
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_dat", rsp_dat, h_dat);
      chk("bp_err", 32'(rsp_err), 32'(h_err));
      chk("bp_to", 32'(rsp_to), 32'(h_to));
      chk("bp_ready", 32'(req_ready), 32'd0);
      chk("bp_stb", 32'(wbm_stb), 32'd0);
    end

    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("rsp_released", 32'(rsp_valid), 32'd0);
    chk("ready_after_rsp", 32'(req_ready), 32'd1);
    chk("no_accept_on_rsp_edge", 32'(wbm_stb), 32'd0);
    req_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_adr = '0; req_dat = '0; req_sel = '0;
    rsp_ready = 1'b0; wbm_dat_i = '0; wbm_ack = 1'b0; wbm_err = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cyc", 32'(wbm_cyc), 32'd0);
    chk("rst_stb", 32'(wbm_stb), 32'd0);
    chk("rst_we", 32'(wbm_we), 32'd0);
    chk("rst_sel", 32'(wbm_sel), 32'd0);
    chk("rst_adr", wbm_adr, 32'd0);
    chk("rst_wdat", wbm_dat_o, 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_dat", rsp_dat, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_rsp_to", 32'(rsp_to), 32'd0);
    chk("rst_ready_held", 32'(req_ready), 32'd0);
    rst = 1'b0;
    step();
    chk("ready_after_release", 32'(req_ready), 32'd1);

    // Stray slave replies while idle must be ignored.
    wbm_ack = 1'b1; wbm_err = 1'b1;
    step();
    wbm_ack = 1'b0; wbm_err = 1'b0;
    chk("idle_ack_stb", 32'(wbm_stb), 32'd0);
    chk("idle_ack_valid", 32'(rsp_valid), 32'd0);
    chk("idle_ack_ready", 32'(req_ready), 32'd1);

    run_txn(1'b0, 32'h3000_0004, 32'h0, 4'hF, 0, 0, 32'hDEAD_BEEF, 0);
    run_txn(1'b1, 32'h3000_0000, 32'h1234_5678, 4'h3, 3, 0, 32'h0, 0);
    run_txn(1'b0, 32'h3000_0008, 32'h0, 4'hF, 0, 3, 32'h0, 0);
    run_txn(1'b0, 32'h3000_000C, 32'h0, 4'hF, 0, 2, 32'hAAAA_5555, 0);
    run_txn(1'b0, 32'h3000_0010, 32'h0, 4'hF, TO - 1, 0, 32'h0BAD_F00D, 0);
    run_txn(1'b1, 32'h3000_0014, 32'h5, 4'h1, TO - 1, 1, 32'h0, 0);
    run_txn(1'b0, 32'h3000_0018, 32'h0, 4'hC, 1, 0, 32'hCAFE_0001, 5);
    run_txn(1'b1, 32'h3000_001C, 32'h7777_0000, 4'h8, 0, 0, 32'h0, 0);

    for (int t = 0; t < 24; t++) begin
      int k;
      k = (t % 3 == 0) ? int'($urandom_range(0, 3)) : 0;
      run_txn(1'($urandom), $urandom, $urandom, 4'($urandom), int'($urandom_range(0, TO + 2)),
              k, $urandom, int'($urandom_range(0, 3)));
    end

    // Reset during the second BUS cycle aborts with no response.
    req_valid = 1'b1; req_we = 1'b0; req_adr = 32'h3000_0020; req_sel = 4'hF;
    step();
    req_valid = 1'b0;
    step();
    chk("pre_abort_stb", 32'(wbm_stb), 32'd1);
    rst = 1'b1;
    step();
    chk("abort_cyc", 32'(wbm_cyc), 32'd0);
    chk("abort_stb", 32'(wbm_stb), 32'd0);
    chk("abort_valid", 32'(rsp_valid), 32'd0);
    chk("abort_ready_held", 32'(req_ready), 32'd0);
    rst = 1'b0;
    wbm_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_abort_valid", 32'(rsp_valid), 32'd0);
      chk("post_abort_ready", 32'(req_ready), 32'd1);
    end
    wbm_ack = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
